seq_alu_unit: RTL and testbench

//  Multi-cycle signed ALU core answering one request per start/done handshake.

---
 rtl/seq_alu_unit.sv | 194 +++++++++++++++++++
 tb/tb_seq_alu_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seq_alu_unit.sv
// seq_alu_unit: multi-cycle signed ALU with one-cycle add/sub, shift-add mul and restoring div.
// Optional macro SEQ_ALU_SIGNED_DIV_EN enables signed division; the default build divides unsigned operands only.

module seq_alu_unit #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         func,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               overflow,
  output logic               err
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Unsigned magnitude; the most negative value maps onto its own bit pattern (-32 -> 32).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      magnitude = negate(v);
    end else begin
      magnitude = v;
    end
  endfunction

  state_t           state_r;
  logic [1:0]       func_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             neg_r;
  logic [CW-1:0]    cnt_r;
  logic [W2-1:0]    acc_r;
  logic [W2-1:0]    mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quot_r;

  logic [WIDTH:0]   arith_s;
  logic [WIDTH:0]   rem_shift_s;
  logic             rem_ge_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [W2-1:0]    fin_out_s;
  logic             fin_ovf_s;
  logic             fin_err_s;

  // Add/sub datapath and one restoring-division step (quot_r starts as the dividend and fills with quotient bits).
  always_comb begin
    arith_s     = '0;
    rem_next_s  = '0;
    if (func_r[0]) begin
      arith_s = {a_r[WIDTH-1], a_r} - {b_r[WIDTH-1], b_r};
    end else begin
      arith_s = {a_r[WIDTH-1], a_r} + {b_r[WIDTH-1], b_r};
    end
    rem_shift_s = {rem_r, quot_r[WIDTH-1]};
    rem_ge_s    = (rem_shift_s >= {1'b0, divisor_r});
    if (rem_ge_s) begin
      rem_next_s = WIDTH'(rem_shift_s - {1'b0, divisor_r});
    end else begin
      rem_next_s = rem_shift_s[WIDTH-1:0];
    end
  end

  // Result, overflow and error values latched on the FINISH cycle.
  always_comb begin
    fin_out_s = '0;
    fin_ovf_s = 1'b0;
    fin_err_s = 1'b0;
    case (func_r)
      2'b00, 2'b01: begin
        fin_out_s = {{WIDTH{arith_s[WIDTH-1]}}, arith_s[WIDTH-1:0]};
        fin_ovf_s = arith_s[WIDTH] ^ arith_s[WIDTH-1];
      end
      2'b10: begin
        if (neg_r) begin
          fin_out_s = ~acc_r + {{(W2-1){1'b0}}, 1'b1};
        end else begin
          fin_out_s = acc_r;
        end
      end
      2'b11: begin
        if (b_r == '0) begin
          fin_out_s = {{WIDTH{1'b1}}, a_r};
          fin_err_s = 1'b1;
        end else begin
`ifdef SEQ_ALU_SIGNED_DIV_EN
          fin_out_s = {(neg_r ? negate(quot_r) : quot_r),
                       (a_r[WIDTH-1] ? negate(rem_r) : rem_r)};
          // Only most-negative / -1 overflows the quotient.
          fin_err_s = (a_r == {1'b1, {(WIDTH-1){1'b0}}}) && (b_r == {WIDTH{1'b1}});
`else
          if (a_r[WIDTH-1] || b_r[WIDTH-1]) begin
            fin_out_s = '0;
            fin_err_s = 1'b1;
          end else begin
            fin_out_s = {quot_r, rem_r};
            fin_err_s = 1'b0;
          end
`endif
        end
      end
      default: begin
        fin_out_s = '0;
      end
    endcase
  end

  // Control FSM, operand capture, iteration registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= '0;
      overflow  <= 1'b0;
      err       <= 1'b0;
      func_r    <= 2'b00;
      a_r       <= '0;
      b_r       <= '0;
      neg_r     <= 1'b0;
      cnt_r     <= '0;
      acc_r     <= '0;
      mcand_r   <= '0;
      mplier_r  <= '0;
      divisor_r <= '0;
      rem_r     <= '0;
      quot_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          // busy still high here means this is the done cycle, so start is dropped.
          if (start && !busy) begin
            busy      <= 1'b1;
            func_r    <= func;
            a_r       <= a;
            b_r       <= b;
            neg_r     <= a[WIDTH-1] ^ b[WIDTH-1];
            cnt_r     <= '0;
            acc_r     <= '0;
            mcand_r   <= {{WIDTH{1'b0}}, magnitude(a)};
            mplier_r  <= magnitude(b);
            divisor_r <= magnitude(b);
            rem_r     <= '0;
            quot_r    <= magnitude(a);
            state_r   <= func[1] ? CALC : FINISH;
          end else begin
            busy <= 1'b0;
          end
        end
        CALC: begin
          acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {W2{1'b0}});
          mcand_r  <= {mcand_r[W2-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          rem_r    <= rem_next_s;
          quot_r   <= {quot_r[WIDTH-2:0], rem_ge_s};
          cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_ITER) begin
            state_r <= FINISH;
          end
        end
        FINISH: begin
          out      <= fin_out_s;
          overflow <= fin_ovf_s;
          err      <= fin_err_s;
          done     <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Directed self-checking bench for seq_alu_unit (WIDTH=6); expected values are hand-computed.

module tb_seq_alu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  func;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        busy;
  logic        done;
  logic [11:0] out;
  logic        overflow;
  logic        err;

  int n_vec  = 0;
  int n_fail = 0;

  seq_alu_unit #(.WIDTH(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .func     (func),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .overflow (overflow),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One request; inputs are scrambled after the accept edge to prove they were captured.
  task automatic run_op(input string tag, input logic [1:0] f, input logic [5:0] av,
                        input logic [5:0] bv, input logic [11:0] eo, input logic eov,
                        input logic eerr, input int elat);
    int lat;
    lat = 0;
    @(negedge clk);
    func = f; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv; func = ~f;
    check({tag, "/busy_after_accept"}, busy, 1);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    check({tag, "/latency"}, lat, elat);
    check({tag, "/out"}, out, eo);
    check({tag, "/overflow"}, overflow, eov);
    check({tag, "/err"}, err, eerr);
    check({tag, "/busy_in_done"}, busy, 1);
    @(negedge clk);
    check({tag, "/done_pulse_end"}, done, 0);
    check({tag, "/busy_end"}, busy, 0);
    check({tag, "/out_hold"}, out, eo);
  endtask

  initial begin
    int lat;
    int ndone;
    rst = 1'b1; start = 1'b1; func = 2'b00; a = 6'h01; b = 6'h01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/out", out, 0);
    check("reset/overflow", overflow, 0);
    check("reset/err", err, 0);
    rst = 1'b0; start = 1'b0;

    run_op("add_31p1",   2'b00, 6'h1F, 6'h01, 12'hFE0, 1'b1, 1'b0, 1);
    run_op("add_10p5",   2'b00, 6'h0A, 6'h05, 12'h00F, 1'b0, 1'b0, 1);
    run_op("add_m32m32", 2'b00, 6'h20, 6'h20, 12'h000, 1'b1, 1'b0, 1);
    run_op("sub_5m7",    2'b01, 6'h05, 6'h07, 12'hFFE, 1'b0, 1'b0, 1);
    run_op("sub_m32m1",  2'b01, 6'h20, 6'h01, 12'h01F, 1'b1, 1'b0, 1);
    run_op("mul_m32m32", 2'b10, 6'h20, 6'h20, 12'h400, 1'b0, 1'b0, 7);
    run_op("mul_m5x7",   2'b10, 6'h3B, 6'h07, 12'hFDD, 1'b0, 1'b0, 7);
    run_op("mul_31xm32", 2'b10, 6'h1F, 6'h20, 12'hC20, 1'b0, 1'b0, 7);
    run_op("mul_0xm5",   2'b10, 6'h00, 6'h3B, 12'h000, 1'b0, 1'b0, 7);
    run_op("div_31d4",   2'b11, 6'h1F, 6'h04, 12'h1C3, 1'b0, 1'b0, 7);
    run_op("div_9d0",    2'b11, 6'h09, 6'h00, 12'hFC9, 1'b0, 1'b1, 7);
    run_op("div_6d7",    2'b11, 6'h06, 6'h07, 12'h006, 1'b0, 1'b0, 7);
`ifdef SEQ_ALU_SIGNED_DIV_EN
    run_op("div_m7d2",   2'b11, 6'h39, 6'h02, 12'hF7F, 1'b0, 1'b0, 7);
    run_op("div_m32dm1", 2'b11, 6'h20, 6'h3F, 12'h800, 1'b0, 1'b1, 7);
`else
    run_op("div_m7d2",   2'b11, 6'h39, 6'h02, 12'h000, 1'b0, 1'b1, 7);
    run_op("div_m32dm1", 2'b11, 6'h20, 6'h3F, 12'h000, 1'b0, 1'b1, 7);
`endif

    // start held high with changing operands through a whole mul, including its done cycle
    @(negedge clk);
    func = 2'b10; a = 6'h20; b = 6'h20; start = 1'b1;
    @(negedge clk);
    func = 2'b00; a = 6'h01; b = 6'h01;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      a = a + 6'h03;
    end
    check("busy_start/latency", lat, 7);
    check("busy_start/out", out, 12'h400);
    check("busy_start/overflow", overflow, 0);
    @(negedge clk);
    check("busy_start/done_cycle_start_dropped", busy, 0);
    check("busy_start/no_second_done", done, 0);
    start = 1'b0;

    // reset during a multiply
    run_op("mul_m5x7_pre", 2'b10, 6'h3B, 6'h07, 12'hFDD, 1'b0, 1'b0, 7);
    @(negedge clk);
    func = 2'b10; a = 6'h03; b = 6'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst/busy", busy, 0);
    check("mid_rst/done", done, 0);
    check("mid_rst/out", out, 0);
    check("mid_rst/overflow", overflow, 0);
    check("mid_rst/err", err, 0);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_rst/no_done", ndone, 0);
    check("mid_rst/idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
